// File: rtl/vga_pkg.sv
// Shared definitions for the VGA overlay pipeline.
// Holds the game phase enum so the overlay and game-logic modules agree on it,
// plus the widths of the digit and frame counters.
package vga_pkg;

    localparam int unsigned DIGIT_W = 3;
    localparam int unsigned FRAME_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        GAME  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

endpackage

// File: rtl/countdown_ctl_edge_rise.sv
// edge_rise: registered rising-edge detector.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset; loads prev with INIT
//   d    - level input to watch
//   rise - high for the cycle where d is 1 and its registered copy is 0
// INIT = 1 suppresses a "rise" for a level already high when reset releases.
module edge_rise #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= INIT;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/countdown_ctl.sv
// countdown_ctl: game-start sequencer for the single-digit overlay.
// Waits for a start press, counts a digit down from COUNT_FROM to 1 at one
// step per FRAMES_PER_STEP frames, then raises is_game_on. On game_over it
// shows 0 for OVER_FRAMES frames and returns to idle. Frames are counted on
// vsync rising edges.
// Ports:
//   clk        - pixel clock
//   rst        - synchronous, active-high reset
//   vsync      - VGA vsync; rising edge is the frame tick
//   start      - start button level; rising edge acted on in IDLE only
//   game_over  - single-cycle pulse; acted on in GAME only
//   number     - registered digit to display
//   is_game_on - registered; high while the game runs
module countdown_ctl
    import vga_pkg::*;
#(
    parameter int unsigned COUNT_FROM      = 3,
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned OVER_FRAMES     = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               start,
    input  logic               game_over,
    output logic [DIGIT_W-1:0] number,
    output logic               is_game_on
);

    localparam logic [DIGIT_W-1:0] FIRST     = DIGIT_W'(COUNT_FROM);
    localparam logic [FRAME_W-1:0] STEP_LAST = FRAME_W'(FRAMES_PER_STEP - 1);
    localparam logic [FRAME_W-1:0] OVER_LAST = FRAME_W'(OVER_FRAMES - 1);

    if (COUNT_FROM == 0 || COUNT_FROM > 7) begin : g_bad_count_from
        $error("countdown_ctl: COUNT_FROM must be 1..7");
    end
    if (FRAMES_PER_STEP == 0 || FRAMES_PER_STEP > 255) begin : g_bad_step
        $error("countdown_ctl: FRAMES_PER_STEP must be 1..255");
    end
    if (OVER_FRAMES == 0 || OVER_FRAMES > 255) begin : g_bad_over
        $error("countdown_ctl: OVER_FRAMES must be 1..255");
    end

    logic tick;
    logic start_rise;

    edge_rise #(.INIT(1'b0)) u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (vsync),
        .rise (tick)
    );

    edge_rise #(.INIT(1'b1)) u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (start),
        .rise (start_rise)
    );

    game_state_t        state, state_n;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_n;
    logic [DIGIT_W-1:0] number_n;
    logic               is_game_on_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            number     <= FIRST;
            is_game_on <= 1'b0;
        end else begin
            state      <= state_n;
            frame_cnt  <= frame_cnt_n;
            number     <= number_n;
            is_game_on <= is_game_on_n;
        end
    end

    always_comb begin
        state_n      = state;
        frame_cnt_n  = frame_cnt;
        number_n     = number;
        is_game_on_n = is_game_on;

        unique case (state)
            IDLE: begin
                number_n     = FIRST;
                is_game_on_n = 1'b0;
                if (start_rise) begin
                    state_n     = COUNT;
                    frame_cnt_n = '0;
                end
            end

            COUNT: begin
                if (tick) begin
                    if (frame_cnt == STEP_LAST) begin
                        frame_cnt_n = '0;
                        // Digit 1 is the last one shown; its expiry starts the game
                        // and the digit stays at 1 rather than dropping to 0.
                        if (number > DIGIT_W'(1)) begin
                            number_n = number - DIGIT_W'(1);
                        end else begin
                            state_n      = GAME;
                            is_game_on_n = 1'b1;
                        end
                    end else begin
                        frame_cnt_n = frame_cnt + FRAME_W'(1);
                    end
                end
            end

            GAME: begin
                is_game_on_n = 1'b1;
                if (game_over) begin
                    state_n      = OVER;
                    is_game_on_n = 1'b0;
                    number_n     = '0;
                    frame_cnt_n  = '0;
                end
            end

            OVER: begin
                if (tick) begin
                    if (frame_cnt == OVER_LAST) begin
                        state_n     = IDLE;
                        number_n    = FIRST;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt + FRAME_W'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_countdown_ctl.sv
module tb_countdown_ctl;

    localparam int CF  = 3;
    localparam int FPS = 2;
    localparam int OF  = 3;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       start;
    logic       game_over;
    logic [2:0] number;
    logic       is_game_on;

    countdown_ctl #(
        .COUNT_FROM      (CF),
        .FRAMES_PER_STEP (FPS),
        .OVER_FRAMES     (OF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .start      (start),
        .game_over  (game_over),
        .number     (number),
        .is_game_on (is_game_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: digit derived from the number of frame ticks since start.
    // mode: 0 idle, 1 counting, 2 playing, 3 showing game-over zero.
    int mode     = 0;
    int ticks    = 0;
    int oticks   = 0;
    int prev_v   = 0;
    int prev_s   = 1;
    int m_number = CF;
    int m_on     = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input logic r, input logic v, input logic s, input logic g);
        int tk;
        int sr;
        if (r) begin
            mode = 0; ticks = 0; oticks = 0; prev_v = 0; prev_s = 1;
        end else begin
            tk = (v && !prev_v) ? 1 : 0;
            sr = (s && !prev_s) ? 1 : 0;
            prev_v = int'(v);
            prev_s = int'(s);
            case (mode)
                0: if (sr != 0) begin mode = 1; ticks = 0; end
                1: if (tk != 0) begin
                       ticks++;
                       if (ticks == CF * FPS) mode = 2;
                   end
                2: if (g) begin mode = 3; oticks = 0; end
                default: if (tk != 0) begin
                       oticks++;
                       if (oticks == OF) mode = 0;
                   end
            endcase
        end
        case (mode)
            0:       begin m_number = CF;               m_on = 0; end
            1:       begin m_number = CF - ticks / FPS; m_on = 0; end
            2:       begin m_number = 1;                m_on = 1; end
            default: begin m_number = 0;                m_on = 0; end
        endcase
    endtask

    // One clock: apply inputs, advance DUT and model together, compare after the edge.
    task automatic cycle(input logic r, input logic v, input logic s, input logic g);
        rst = r; vsync = v; start = s; game_over = g;
        @(posedge clk);
        model_step(r, v, s, g);
        #1;
        chk("model_number", int'(number), m_number);
        chk("model_is_game_on", int'(is_game_on), m_on);
    endtask

    typedef struct {
        logic r;
        logic v;
        logic s;
        logic g;
        int   exp_num;
        int   exp_on;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic s, input logic g,
                       input int en, input int eo);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.g = g; t.exp_num = en; t.exp_on = eo;
        vecs.push_back(t);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; start = 1'b0; game_over = 1'b0;

        // ---------------- table-driven scenario ----------------
        //   rst v  s  go   num on
        add(1, 0, 1, 0,   3, 0);  // start held through reset
        add(0, 0, 1, 0,   3, 0);  // no start on release
        add(0, 1, 1, 0,   3, 0);  // tick in idle ignored
        add(0, 0, 0, 0,   3, 0);
        add(0, 0, 1, 0,   3, 0);  // press -> counting
        add(0, 1, 1, 1,   3, 0);  // tick 1, game_over ignored
        add(0, 0, 1, 0,   3, 0);
        add(0, 1, 1, 0,   2, 0);  // tick 2 -> 2
        add(0, 0, 1, 0,   2, 0);
        add(0, 1, 1, 0,   2, 0);
        add(0, 0, 1, 0,   2, 0);
        add(0, 1, 1, 0,   1, 0);  // tick 4 -> 1
        add(0, 0, 1, 0,   1, 0);
        add(0, 1, 1, 0,   1, 0);
        add(0, 0, 1, 0,   1, 0);
        add(0, 1, 1, 0,   1, 1);  // tick 6 -> game on
        add(0, 0, 1, 0,   1, 1);
        add(0, 0, 0, 0,   1, 1);
        add(0, 0, 1, 1,   0, 0);  // game_over with start rise: game_over wins
        add(0, 1, 0, 0,   0, 0);  // over tick 1
        add(0, 0, 0, 0,   0, 0);
        add(0, 1, 0, 0,   0, 0);  // over tick 2
        add(0, 0, 0, 0,   0, 0);
        add(0, 1, 0, 0,   3, 0);  // over tick 3 -> idle
        add(0, 0, 1, 0,   3, 0);  // press -> counting
        add(0, 1, 1, 0,   3, 0);
        add(0, 0, 1, 0,   3, 0);
        add(0, 1, 1, 0,   2, 0);  // number 2
        add(1, 0, 1, 0,   3, 0);  // reset mid-count
        add(0, 1, 1, 0,   3, 0);  // held start after reset: no start
        add(0, 0, 1, 0,   3, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].g);
            chk($sformatf("vec%0d_number", i), int'(number), vecs[i].exp_num);
            chk($sformatf("vec%0d_is_game_on", i), int'(is_game_on), vecs[i].exp_on);
        end

        // ---------------- hand sequence: vsync every 20 clocks ----------------
        begin
            int seen_on;
            int seen_idle;
            int go_cycle;
            cycle(1, 0, 0, 0);
            cycle(0, 0, 0, 0);
            cycle(0, 0, 1, 0);
            cycle(0, 0, 0, 0);
            seen_on = -1;
            for (int i = 1; i <= 400 && seen_on < 0; i++) begin
                cycle(0, (i % 20) == 0, 0, 0);
                if (is_game_on) seen_on = i;
            end
            // game starts on the 6th vsync rise after the press
            chk("game_on_cycle", seen_on, 120);
            cycle(0, 0, 0, 1);
            chk("over_number", int'(number), 0);
            chk("over_is_game_on", int'(is_game_on), 0);
            seen_idle = -1;
            go_cycle  = 0;
            for (int i = 1; i <= 200 && seen_idle < 0; i++) begin
                cycle(0, (i % 20) == 0, 0, 0);
                if (number == 3'd3) seen_idle = i;
            end
            chk("over_return_cycle", seen_idle, 60);
            chk("idle_is_game_on", int'(is_game_on), go_cycle);
        end

        // ---------------- randomized against the model ----------------
        begin
            logic s_lvl;
            s_lvl = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) s_lvl = ~s_lvl;
                cycle($urandom_range(0, 299) == 0,
                      $urandom_range(0, 4) == 0,
                      s_lvl,
                      $urandom_range(0, 5) == 0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
